// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request and result/flag channels of the sequential ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 flag_zero;
    logic                 flag_carry;
    logic                 flag_ovf;
    logic                 flag_dz;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dz
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dz
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake. Add/sub/inc/dec/shift
// complete in one clock; multiply, divide and modulo iterate one bit per clock.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZEROS    = '0;

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_RSUB = 4'h2, OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4, OP_RDIV = 4'h5, OP_INCA = 4'h6, OP_INCB = 4'h7;
    localparam logic [3:0] OP_DECA = 4'h8, OP_DECB = 4'h9, OP_SHLA = 4'hA, OP_SRAA = 4'hB;
    localparam logic [3:0] OP_SHLB = 4'hC, OP_SRAB = 4'hD, OP_MOD  = 4'hE, OP_RMOD = 4'hF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

    logic [WIDTH-1:0]     arith_x, arith_y, dvd, dvs;
    logic                 arith_sub, arith_ovf;
    logic [WIDTH:0]       arith_sum;
    logic [2*WIDTH-1:0]   sc_result;
    logic                 sc_carry, sc_ovf, sc_dz, sc_iter;

    logic [2*WIDTH-1:0]   mul_acc_nx;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [WIDTH-1:0]     div_rem_nx, div_quo_nx;
    logic [2*WIDTH-1:0]   busy_result;

    // Pick adder operands and direction; carry-out of the (WIDTH+1)-bit sum doubles as borrow.
    always_comb begin
        arith_x   = bus.a;
        arith_y   = bus.b;
        arith_sub = 1'b0;
        case (bus.op)
            OP_SUB:  arith_sub = 1'b1;
            OP_RSUB: begin arith_x = bus.b; arith_y = bus.a; arith_sub = 1'b1; end
            OP_INCA: arith_y = ONE;
            OP_INCB: begin arith_x = bus.b; arith_y = ONE; end
            OP_DECA: begin arith_y = ONE; arith_sub = 1'b1; end
            OP_DECB: begin arith_x = bus.b; arith_y = ONE; arith_sub = 1'b1; end
            default: ;
        endcase
        if (arith_sub) begin
            arith_sum = {1'b0, arith_x} - {1'b0, arith_y};
        end else begin
            arith_sum = {1'b0, arith_x} + {1'b0, arith_y};
        end
        arith_ovf = ((arith_x[WIDTH-1] ^ arith_y[WIDTH-1]) == arith_sub) &&
                    (arith_sum[WIDTH-1] != arith_x[WIDTH-1]);
    end

    // Result of everything that finishes at acceptance, and whether the op must iterate instead.
    always_comb begin
        dvd       = (bus.op == OP_RDIV || bus.op == OP_RMOD) ? bus.b : bus.a;
        dvs       = (bus.op == OP_RDIV || bus.op == OP_RMOD) ? bus.a : bus.b;
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_dz     = 1'b0;
        sc_iter   = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB, OP_RSUB, OP_INCA, OP_INCB, OP_DECA, OP_DECB: begin
                sc_result = {ZEROS, arith_sum[WIDTH-1:0]};
                sc_carry  = arith_sum[WIDTH];
                sc_ovf    = arith_ovf;
            end
            OP_MUL: sc_iter = 1'b1;
            OP_DIV, OP_RDIV: begin
                if (dvs == ZEROS) begin
                    sc_result = {ZEROS, ~ZEROS};
                    sc_dz     = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            OP_MOD, OP_RMOD: begin
                if (dvs == ZEROS) begin
                    sc_result = {ZEROS, dvd};
                    sc_dz     = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            OP_SHLA: begin sc_result = {ZEROS, bus.a[WIDTH-2:0], 1'b0}; sc_carry = bus.a[WIDTH-1]; end
            OP_SRAA: begin sc_result = {ZEROS, bus.a[WIDTH-1], bus.a[WIDTH-1:1]}; sc_carry = bus.a[0]; end
            OP_SHLB: begin sc_result = {ZEROS, bus.b[WIDTH-2:0], 1'b0}; sc_carry = bus.b[WIDTH-1]; end
            OP_SRAB: begin sc_result = {ZEROS, bus.b[WIDTH-1], bus.b[WIDTH-1:1]}; sc_carry = bus.b[0]; end
            default: ;
        endcase
    end

    // One shift-add multiply step and one restoring-division step; the remainder lives in acc_q.
    always_comb begin
        mul_acc_nx = shreg_q[0] ? (acc_q + mcand_q) : acc_q;
        div_shift  = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
        if (!div_diff[WIDTH]) begin
            div_rem_nx = div_diff[WIDTH-1:0];
            div_quo_nx = {shreg_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nx = div_shift[WIDTH-1:0];
            div_quo_nx = {shreg_q[WIDTH-2:0], 1'b0};
        end
        if (op_q == OP_MUL) begin
            busy_result = mul_acc_nx;
        end else if (op_q == OP_DIV || op_q == OP_RDIV) begin
            busy_result = {ZEROS, div_quo_nx};
        end else begin
            busy_result = {ZEROS, div_rem_nx};
        end
    end

    // Handshake FSM: latch on acceptance, iterate in BUSY, hold the result in DONE until taken.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d     = bus.op;
                    result_d = '0;
                    zero_d   = 1'b0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    if (sc_iter) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                        acc_d   = '0;
                        if (bus.op == OP_MUL) begin
                            mcand_d = {ZEROS, bus.a};
                            shreg_d = bus.b;
                        end else begin
                            mcand_d = {ZEROS, dvs};
                            shreg_d = dvd;
                        end
                    end else begin
                        state_d  = DONE;
                        result_d = sc_result;
                        zero_d   = (sc_result == '0);
                        carry_d  = sc_carry;
                        ovf_d    = sc_ovf;
                        dz_d     = sc_dz;
                    end
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    acc_d   = mul_acc_nx;
                    mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end else begin
                    acc_d   = {ZEROS, div_rem_nx};
                    shreg_d = div_quo_nx;
                end
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = busy_result;
                    zero_d   = (busy_result == '0);
                    carry_d  = (op_q == OP_MUL) && (busy_result[2*WIDTH-1:WIDTH] != ZEROS);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;
    assign bus.flag_dz    = dz_q;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the team's 8-bit combinational ALU. It accepts one operation at a time over a valid/ready handshake. Single-cycle ops produce a registered result one clock after acceptance. Multiply, divide and modulo run iteratively over WIDTH cycles. It returns a full-width result plus status flags, and sits between the operand register file and the writeback stage of the datapath.

Parameters:
WIDTH, 8, operand width in bits (legal range 4..32)

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A, unsigned except where noted
b  in  WIDTH  operand B
op  in  4  operation code
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  result; upper WIDTH bits zero except for MUL
flag_zero  out  1  result == 0
flag_carry  out  1  carry out (add/inc), borrow (sub/dec), shifted-out bit (shifts)
flag_ovf  out  1  signed overflow on add/sub/inc/dec
flag_dz  out  1  divide/modulo by zero

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Op codes:
  - 0 A+B, 1 A-B, 2 B-A, 3 A*B (unsigned, 2*WIDTH result)
  - 4 A/B, 5 B/A
  - 6 A+1, 7 B+1, 8 A-1, 9 B-1
  - A: A<<1 (logical), B: A>>>1 (arithmetic, MSB replicated), C: B<<1, D: B>>>1
  - E: A%B, F: B%A
- Reset state: state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0. Datapath registers are cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready; a, b and op are latched that cycle. Single-cycle ops go to DONE with result registered. Ops 3/4/5/E/F with a nonzero divisor go to BUSY with an iteration counter loaded to WIDTH-1.
  - BUSY: in_ready=0. MUL uses one shift-add step per cycle; DIV/MOD use one restoring-division step per cycle. When the counter reaches 0, the result is registered and the FSM goes to DONE. Total latency is WIDTH+1 clocks from acceptance to out_valid.
  - DONE: out_valid=1 and in_ready=0. Result and flags hold stable until out_valid&&out_ready, then the FSM returns to IDLE. There is no same-cycle re-accept: in_ready rises the cycle after the output handshake.
- Latency: single-cycle ops assert out_valid one clock after acceptance. Divide by zero also takes 1 clock.
- Arithmetic and width rules:
  - Add/sub/inc/dec results are WIDTH bits, zero-extended.
  - flag_carry: add and inc report carry-out; sub and dec report borrow (1 when minuend < subtrahend).
  - flag_ovf: set on two's-complement overflow of the WIDTH-bit operation. It is 0 for MUL/DIV/MOD/shifts.
  - Shifts: flag_carry is the bit shifted out.
  - MUL: full 2*WIDTH product; flag_carry=1 when the upper half is nonzero.
  - flag_zero is evaluated on the full result.
- Divide/modulo by zero (divisor==0): quotient is all ones (WIDTH bits), remainder equals the dividend, flag_dz=1. This takes the single-cycle path; BUSY is not entered.
- Undefined op: none, since all 16 codes are defined.
- Input stability: a, b and op changing while not in IDLE are ignored, because operands are latched at acceptance.
- Output stall: out_ready held low keeps DONE indefinitely; no new operation is accepted.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. The in-flight operation is discarded.
- Flags are cleared to 0 on every acceptance and are valid only while out_valid=1.

Test Plan:
- WIDTH=8. Reset, then accept op=0 with a=200, b=100 -> next cycle out_valid=1, result=44, flag_carry=1, flag_ovf=0; out_ready=1 -> in_ready=1 the following cycle.
- op=1, a=0x80, b=0x01 -> result=0x7F, flag_ovf=1, flag_carry=0; op=2 with the same operands -> result=0x81, flag_carry=1.
- op=3, a=255, b=255 -> out_valid exactly 9 cycles after accept, result=16'hFE01, flag_carry=1; in_ready=0 throughout BUSY.
- op=4, a=200, b=7 -> result=28, 9-cycle latency; op=E with the same operands -> result=4; op=4 with b=0 -> result=0xFF, flag_dz=1, 1-cycle latency.
- op=B, a=0x81 -> result=0xC0, flag_carry=1; op=A, a=0x81 -> result=0x02, flag_carry=1.
- Accept op=3, deassert rst_n on cycle 4 of BUSY -> outputs reset immediately; after release, a fresh op=0 with a=1, b=1 -> result=2. Holding out_ready=0 for 5 cycles in DONE keeps result stable, and in_valid is ignored during that time.
